// File: rtl/router_fc_pkg.sv
// ============================================================================
// Module   : router_fc_pkg
// Purpose  : Shared constants for the router credit flow-control slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_fc_pkg;

  localparam int PORT_N   = 0;
  localparam int PORT_E   = 1;
  localparam int PORT_W   = 2;
  localparam int PORT_S   = 3;
  localparam int PORT_L   = 4;

  localparam int FC_NUM_PORTS = 5;
  localparam int FC_DEPTH     = 4;
  localparam int STALL_W      = 16;

endpackage

`default_nettype wire

// File: rtl/fc_credit_counter.sv
// ============================================================================
// Module   : fc_credit_counter
// Purpose  : One output port's credit counter, sticky error flag and optional
//            saturating stall counter (built only with FC_STALL_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_credit_counter
  import router_fc_pkg::*;
#(
  parameter int DEPTH = FC_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               flit_sent,
  input  logic               credit_in,
  output logic               ready,
  output logic [CNT_W-1:0]   cnt,
  output logic               err,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  assign ready = !rst && sel && (cnt != '0);

  // Send+return in the same cycle nets to zero even at cnt==0 (cycle-through).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_MAX;
      err <= 1'b0;
    end else begin
      case ({flit_sent, credit_in})
        2'b10: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else           err <= 1'b1;
        end
        2'b01: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          else                err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FC_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (sel && (cnt == '0) && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/router_credit_flowcontrol.sv
// ============================================================================
// Module   : router_credit_flowcontrol
// Purpose  : Per-port credit-based ready gating between routing and arbiter.
//            Optional stall counters enabled by defining FC_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_credit_flowcontrol
  import router_fc_pkg::*;
#(
  parameter int NUM_PORTS = FC_NUM_PORTS,
  parameter int DEPTH     = FC_DEPTH,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         port_sel,
  input  logic [NUM_PORTS-1:0]         flit_sent,
  input  logic [NUM_PORTS-1:0]         credit_in,
  output logic [NUM_PORTS-1:0]         ready_out,
  output logic [NUM_PORTS*CNT_W-1:0]   credit_cnt,
  output logic [NUM_PORTS-1:0]         credit_err,
  output logic [NUM_PORTS*STALL_W-1:0] stall_cnt
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    fc_credit_counter #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .sel       (port_sel[i]),
      .flit_sent (flit_sent[i]),
      .credit_in (credit_in[i]),
      .ready     (ready_out[i]),
      .cnt       (credit_cnt[i*CNT_W +: CNT_W]),
      .err       (credit_err[i]),
      .stall_cnt (stall_cnt[i*STALL_W +: STALL_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_router_credit_flowcontrol.sv
// ============================================================================
// Module   : tb_router_credit_flowcontrol
// Purpose  : Directed self-checking bench for router_credit_flowcontrol
//            (default 5x4 instance plus a 3x1 instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_credit_flowcontrol;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [4:0]  port_sel  = '0;
  logic [4:0]  flit_sent = '0;
  logic [4:0]  credit_in = '0;
  logic [4:0]  ready_out;
  logic [14:0] credit_cnt;
  logic [4:0]  credit_err;
  logic [79:0] stall_cnt;

  logic [2:0]  s_sel  = '0;
  logic [2:0]  s_sent = '0;
  logic [2:0]  s_cred = '0;
  logic [2:0]  s_ready;
  logic [2:0]  s_cnt;
  logic [2:0]  s_err;
  logic [47:0] s_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_credit_flowcontrol #(.NUM_PORTS(5), .DEPTH(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .port_sel   (port_sel),
    .flit_sent  (flit_sent),
    .credit_in  (credit_in),
    .ready_out  (ready_out),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .stall_cnt  (stall_cnt)
  );

  router_credit_flowcontrol #(.NUM_PORTS(3), .DEPTH(1)) u_small (
    .clk        (clk),
    .rst        (rst),
    .port_sel   (s_sel),
    .flit_sent  (s_sent),
    .credit_in  (s_cred),
    .ready_out  (s_ready),
    .credit_cnt (s_cnt),
    .credit_err (s_err),
    .stall_cnt  (s_stall)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] cnt_of(input int p);
    return credit_cnt[p*3 +: 3];
  endfunction

  task automatic pulse(input logic [4:0] fs, input logic [4:0] ci);
    flit_sent = fs;
    credit_in = ci;
    step();
    flit_sent = '0;
    credit_in = '0;
  endtask

  initial begin
    logic [15:0] exp_stall0;
    logic [15:0] exp_small_stall;

    // Asynchronous reset, mid-cycle, with a port selected
    port_sel = 5'b11111;
    #3 rst = 1'b1;
    #1;
    check("rst_cnt",   credit_cnt, {5{3'd4}});
    check("rst_err",   credit_err, 5'b0);
    check("rst_ready", ready_out,  5'b0);
    check("rst_stall", stall_cnt,  80'd0);
    check("rst_small", s_cnt,      3'b111);
    step();
    rst = 1'b0;
    port_sel = 5'b00100;
    #1;
    check("post_rst_ready", ready_out, 5'b00100);

    // Drain port 0
    port_sel = 5'b00001;
    #1;
    check("drain_ready4", ready_out, 5'b00001);
    for (int k = 3; k >= 0; k--) begin
      pulse(5'b00001, 5'b0);
      check($sformatf("drain_cnt%0d", k), cnt_of(0), 3'(k));
    end
    check("drain_ready0", ready_out, 5'b00000);
    check("drain_err", credit_err, 5'b0);
    step();
    step();
`ifdef FC_STALL_CNT_EN
    exp_stall0 = 16'd2;
`else
    exp_stall0 = 16'd0;
`endif
    check("stall0_2", stall_cnt[15:0], exp_stall0);

    // Return one credit at cnt==0
    pulse(5'b0, 5'b00001);
    check("ret_cnt", cnt_of(0), 3'd1);
    check("ret_ready", ready_out, 5'b00001);
    check("ret_err", credit_err, 5'b0);
`ifdef FC_STALL_CNT_EN
    exp_stall0 = 16'd3;
`endif
    step();
    check("stall0_3", stall_cnt[15:0], exp_stall0);
    port_sel = 5'b0;

    // Simultaneous send+return on port 1
    pulse(5'b00010, 5'b0);
    pulse(5'b00010, 5'b0);
    check("sim_pre2", cnt_of(1), 3'd2);
    pulse(5'b00010, 5'b00010);
    check("sim_cnt2", cnt_of(1), 3'd2);
    pulse(5'b00010, 5'b0);
    pulse(5'b00010, 5'b0);
    check("sim_pre0", cnt_of(1), 3'd0);
    pulse(5'b00010, 5'b00010);
    check("sim_cnt0", cnt_of(1), 3'd0);
    check("sim_err", credit_err[1], 1'b0);

    // Underflow on port 2, overflow on port 3
    for (int k = 0; k < 4; k++) pulse(5'b00100, 5'b0);
    pulse(5'b00100, 5'b0);
    check("under_cnt", cnt_of(2), 3'd0);
    check("under_err", credit_err, 5'b00100);
    pulse(5'b0, 5'b00100);
    check("under_ret", cnt_of(2), 3'd1);
    pulse(5'b0, 5'b01000);
    check("over_cnt", cnt_of(3), 3'd4);
    step();
    check("err_sticky", credit_err, 5'b01100);
    check("indep_cnt", credit_cnt, {3'd4, 3'd4, 3'd1, 3'd0, 3'd1});

    // DEPTH=1, three ports: send, credit, send on port 0
    s_sel = 3'b001;
    #1;
    check("small_ready1", s_ready, 3'b001);
    s_sent = 3'b001; step(); s_sent = '0;
    check("small_c0a", s_cnt, 3'b110);
    check("small_rdy0", s_ready, 3'b000);
    s_cred = 3'b001; step(); s_cred = '0;
    check("small_c1", s_cnt, 3'b111);
    s_sent = 3'b001; step(); s_sent = '0;
    check("small_c0b", s_cnt, 3'b110);
    step();
    check("small_err", s_err, 3'b000);
`ifdef FC_STALL_CNT_EN
    exp_small_stall = 16'd2;
`else
    exp_small_stall = 16'd0;
`endif
    check("small_stall", s_stall, {32'd0, exp_small_stall});

    // Mid-operation asynchronous reset clears everything
    #2 rst = 1'b1;
    #1;
    check("rst2_cnt", credit_cnt, {5{3'd4}});
    check("rst2_err", credit_err, 5'b0);
    check("rst2_small", s_ready, 3'b000);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
